tcpv4_tx_arbiter: RTL and testbench

Grants the shared TCP transmit path to one of several TCP clients (UART bridges, register servers, etc.) using each client's rts/cts handshake, then forwards that client's TCPv4TxBus frame to the TCP stack. It is the counterpart of the client-side rts/cts logic and sits in the TCP clock domain between the clients and the TCPv4 transmit engine. Arbitration is round-robin and frame-atomic, with a start-timeout watchdog so that a stuck client cannot hold the bus.

---
 rtl/tcpv4_tx_arbiter_pkg.sv | 39 +++
 rtl/RoundRobinSelector.sv | 41 ++++
 rtl/tcpv4_tx_arbiter.sv | 162 ++++++++++++++++
 tb/tb_tcpv4_tx_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/tcpv4_tx_arbiter_pkg.sv
// Shared types for the TCPv4 transmit arbiter: the client/stack frame bus,
// the arbiter state encoding and small helpers used by the arbiter slice.
package tcpv4_tx_arbiter_pkg;

    localparam int DATA_W    = 32;
    localparam int MAX_PORTS = 16;
    localparam int CNT_W     = 16;

    typedef struct packed {
        logic              start;
        logic              dataValid;
        logic [1:0]        bytesValid;
        logic [DATA_W-1:0] data;
        logic              commit;
        logic              drop;
        logic [31:0]       dstIp;
        logic [15:0]       dstPort;
        logic [15:0]       srcPort;
        logic [7:0]        sockId;
    } TCPv4TxBus;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY
    } arbState_t;

    // Wide enough for any legal port count; arbiters slice it down to their own width.
    typedef logic [$clog2(MAX_PORTS)-1:0] portIndex_t;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 16'd1;
    endfunction

    function automatic logic hasControl(input TCPv4TxBus bus);
        return bus.start | bus.dataValid | bus.commit | bus.drop;
    endfunction

endpackage

// File: rtl/RoundRobinSelector.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping, returned as a one-hot grant plus its index.
module RoundRobinSelector
    import tcpv4_tx_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [IW-1:0] i_pointer,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_index,
    output logic          o_valid
);

    always_comb begin
        logic [IW:0]   sum;
        portIndex_t    candWide;
        logic [IW-1:0] cand;
        o_grant  = '0;
        o_index  = '0;
        o_valid  = 1'b0;
        sum      = '0;
        candWide = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, i_pointer} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            candWide = portIndex_t'(sum);
            cand     = candWide[IW-1:0];
            if (!o_valid && i_request[cand]) begin
                o_valid       = 1'b1;
                o_grant[cand] = 1'b1;
                o_index       = cand;
            end
        end
    end

endmodule

// File: rtl/tcpv4_tx_arbiter.sv
// Round-robin, frame-atomic arbiter handing the TCP transmit path to one client
// at a time via rts/cts, with a start watchdog and stray-control detection.
module tcpv4_tx_arbiter
    import tcpv4_tx_arbiter_pkg::*;
#(
    parameter  int NUM_PORTS     = 4,
    parameter  int START_TIMEOUT = 255,
    localparam int IW            = $clog2(NUM_PORTS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] i_clientRts,
    output logic [NUM_PORTS-1:0] o_clientCts,
    input  TCPv4TxBus            i_clientTxBus [NUM_PORTS],
    output TCPv4TxBus            o_tcpTxBus,
    output logic                 o_busy,
    output logic [IW-1:0]        o_grantId,
    output logic                 o_startTimeoutErr,
    output logic                 o_protocolErr
);

    arbState_t            r_state;
    logic [IW-1:0]        r_rrPtr;
    logic [IW-1:0]        r_grantId;
    logic [NUM_PORTS-1:0] r_cts;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    TCPv4TxBus            r_txBus;
    logic                 r_timeoutErr;
    logic                 r_protocolErr;

    logic [NUM_PORTS-1:0] w_selGrant;
    logic [IW-1:0]        w_selIndex;
    logic                 w_selValid;
    TCPv4TxBus            w_granted;
    TCPv4TxBus            w_fwdBus;
    TCPv4TxBus            w_payloadBus;
    TCPv4TxBus            w_heldBus;
    logic                 w_strayControl;
    logic [IW-1:0]        w_nextPtr;
    logic                 w_timeoutHit;

    RoundRobinSelector #(.N(NUM_PORTS)) u_selector (
        .i_request (i_clientRts),
        .i_pointer (r_rrPtr),
        .o_grant   (w_selGrant),
        .o_index   (w_selIndex),
        .o_valid   (w_selValid)
    );

    assign w_granted    = i_clientTxBus[r_grantId];
    assign w_nextPtr    = (r_grantId == IW'(NUM_PORTS-1)) ? '0 : r_grantId + IW'(1);
    assign w_timeoutHit = (r_cnt == CNT_W'(START_TIMEOUT-1));

    // A drop in the same cycle as commit wins, so the stack discards the frame.
    always_comb begin
        w_fwdBus        = w_granted;
        w_fwdBus.commit = w_granted.commit & ~w_granted.drop;

        w_payloadBus           = w_granted;
        w_payloadBus.start     = 1'b0;
        w_payloadBus.dataValid = 1'b0;
        w_payloadBus.commit    = 1'b0;
        w_payloadBus.drop      = 1'b0;

        w_heldBus           = r_txBus;
        w_heldBus.start     = 1'b0;
        w_heldBus.dataValid = 1'b0;
        w_heldBus.commit    = 1'b0;
        w_heldBus.drop      = 1'b0;
    end

    // In IDLE nobody owns the bus, so every client counts as non-granted.
    always_comb begin
        w_strayControl = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!((r_state != ST_IDLE) && (r_grantId == IW'(i))) &&
                hasControl(i_clientTxBus[i])) begin
                w_strayControl = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_rrPtr       <= '0;
            r_grantId     <= '0;
            r_cts         <= '0;
            r_busy        <= 1'b0;
            r_cnt         <= '0;
            r_txBus       <= '0;
            r_timeoutErr  <= 1'b0;
            r_protocolErr <= 1'b0;
        end else begin
            r_cts         <= '0;
            r_timeoutErr  <= 1'b0;
            r_protocolErr <= w_strayControl;
            r_txBus       <= w_heldBus;

            case (r_state)
                ST_IDLE: begin
                    if (w_selValid) begin
                        r_cts     <= w_selGrant;
                        r_grantId <= w_selIndex;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= ST_GRANT;
                    end
                end

                // Start is checked first so a start on the expiry cycle still wins.
                ST_GRANT: begin
                    r_txBus <= w_payloadBus;
                    if (w_granted.start) begin
                        r_txBus <= w_fwdBus;
                        if (w_granted.commit || w_granted.drop) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_rrPtr <= w_nextPtr;
                        end else begin
                            r_state <= ST_BUSY;
                        end
                    end else if (w_granted.drop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_rrPtr <= w_nextPtr;
                    end else if (w_timeoutHit) begin
                        r_timeoutErr <= 1'b1;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_rrPtr      <= w_nextPtr;
                    end else begin
                        r_cnt <= satInc(r_cnt);
                    end
                end

                ST_BUSY: begin
                    r_txBus <= w_fwdBus;
                    if (w_granted.commit || w_granted.drop) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_rrPtr <= w_nextPtr;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clientCts       = r_cts;
    assign o_tcpTxBus        = r_txBus;
    assign o_busy            = r_busy;
    assign o_grantId         = r_grantId;
    assign o_startTimeoutErr = r_timeoutErr;
    assign o_protocolErr     = r_protocolErr;

endmodule

// File: tb/tb_tcpv4_tx_arbiter.sv
// Directed self-checking bench for tcpv4_tx_arbiter: grants, frame forwarding,
// rotation, start timeout, stray control detection and mid-frame reset.
module tb_tcpv4_tx_arbiter;
    import tcpv4_tx_arbiter_pkg::*;

    localparam int NUM_PORTS     = 4;
    localparam int START_TIMEOUT = 10;
    localparam int IW            = $clog2(NUM_PORTS);

    logic                 clk;
    logic                 rst;
    logic [NUM_PORTS-1:0] clientRts;
    logic [NUM_PORTS-1:0] clientCts;
    TCPv4TxBus            clientBus [NUM_PORTS];
    TCPv4TxBus            tcpTxBus;
    logic                 busy;
    logic [IW-1:0]        grantId;
    logic                 startTimeoutErr;
    logic                 protocolErr;

    int testCount = 0;
    int failCount = 0;

    tcpv4_tx_arbiter #(
        .NUM_PORTS     (NUM_PORTS),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_clientRts       (clientRts),
        .o_clientCts       (clientCts),
        .i_clientTxBus     (clientBus),
        .o_tcpTxBus        (tcpTxBus),
        .o_busy            (busy),
        .o_grantId         (grantId),
        .o_startTimeoutErr (startTimeoutErr),
        .o_protocolErr     (protocolErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic start, input logic dataValid,
                                 input logic commit, input logic drop, input logic [31:0] data);
        clientBus[port].start      = start;
        clientBus[port].dataValid  = dataValid;
        clientBus[port].commit     = commit;
        clientBus[port].drop       = drop;
        clientBus[port].data       = data;
        clientBus[port].bytesValid = 2'd3;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        clientRts = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            clientBus[i]         = '0;
            clientBus[i].dstIp   = 32'hC0A80100 + 32'(i);
            clientBus[i].dstPort = 16'(80 + i);
            clientBus[i].srcPort = 16'(5000 + i);
            clientBus[i].sockId  = 8'(i);
        end
        tick();
        tick();

        checkOutput("resetBus",      128'(tcpTxBus),        128'h0);
        checkOutput("resetCts",      128'(clientCts),       128'h0);
        checkOutput("resetBusy",     128'(busy),            128'h0);
        checkOutput("resetGrantId",  128'(grantId),         128'h0);
        checkOutput("resetTimeout",  128'(startTimeoutErr), 128'h0);
        checkOutput("resetProtocol", 128'(protocolErr),     128'h0);

        // Single client 0, three-word frame
        rst          = 1'b0;
        clientRts[0] = 1'b1;
        tick();
        checkOutput("c0Cts",     128'(clientCts), 128'h1);
        checkOutput("c0Busy",    128'(busy),      128'h1);
        checkOutput("c0GrantId", 128'(grantId),   128'h0);
        clientRts[0] = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hA0A0_0000);
        tick();
        checkOutput("c0CtsPulse", 128'(clientCts),      128'h0);
        checkOutput("c0Start",    128'(tcpTxBus.start), 128'h1);
        checkOutput("c0Word0",    128'(tcpTxBus.data),  128'hA0A0_0000);
        checkOutput("c0DstIp",    128'(tcpTxBus.dstIp), 128'hC0A8_0100);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA0A0_0001);
        tick();
        checkOutput("c0StartLow", 128'(tcpTxBus.start),     128'h0);
        checkOutput("c0Word1",    128'(tcpTxBus.data),      128'hA0A0_0001);
        checkOutput("c0Valid1",   128'(tcpTxBus.dataValid), 128'h1);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA0A0_0002);
        tick();
        checkOutput("c0Word2",  128'(tcpTxBus.data),   128'hA0A0_0002);
        checkOutput("c0Commit", 128'(tcpTxBus.commit), 128'h1);
        checkOutput("c0BusyEnd",128'(busy),            128'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("c0CommitLow", 128'(tcpTxBus.commit), 128'h0);
        checkOutput("c0DstIpHeld", 128'(tcpTxBus.dstIp),  128'hC0A8_0100);

        // Clients 1 and 3 together; 1 re-requests during 3's frame
        clientRts[1] = 1'b1;
        clientRts[3] = 1'b1;
        tick();
        checkOutput("rr1Cts",     128'(clientCts), 128'h2);
        checkOutput("rr1GrantId", 128'(grantId),   128'h1);
        clientRts[1] = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB0B0_0000);
        tick();
        checkOutput("rr1Word0", 128'(tcpTxBus.data), 128'hB0B0_0000);
        applyStimulus(1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB0B0_0001);
        tick();
        checkOutput("rr1Commit", 128'(tcpTxBus.commit), 128'h1);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("rr3Cts",     128'(clientCts), 128'h8);
        checkOutput("rr3GrantId", 128'(grantId),   128'h3);
        clientRts[3] = 1'b0;
        applyStimulus(3, 1'b1, 1'b1, 1'b0, 1'b0, 32'hC0C0_0000);
        tick();
        clientRts[1] = 1'b1;
        applyStimulus(3, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC0C0_0001);
        tick();
        checkOutput("rr3Commit",  128'(tcpTxBus.commit),  128'h1);
        checkOutput("rr3DstPort", 128'(tcpTxBus.dstPort), 128'd83);
        applyStimulus(3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("rr1AgainCts", 128'(clientCts), 128'h2);
        clientRts[1] = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        tick();
        checkOutput("earlyDropHidden", 128'(tcpTxBus.drop), 128'h0);
        checkOutput("earlyDropIdle",   128'(busy),          128'h0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Client 2 never starts; client 0 waits behind it
        clientRts[2] = 1'b1;
        clientRts[0] = 1'b1;
        tick();
        checkOutput("toCts", 128'(clientCts), 128'h4);
        clientRts[2] = 1'b0;
        for (int k = 1; k < START_TIMEOUT; k++) begin
            tick();
            checkOutput("toNotYet", 128'(startTimeoutErr), 128'h0);
        end
        tick();
        checkOutput("toPulse", 128'(startTimeoutErr), 128'h1);
        checkOutput("toBusy",  128'(busy),            128'h0);
        tick();
        checkOutput("toPulseLow", 128'(startTimeoutErr), 128'h0);
        checkOutput("toNextCts",  128'(clientCts),       128'h1);
        checkOutput("toNextId",   128'(grantId),         128'h0);
        clientRts[0] = 1'b0;

        // Client 2 drives data_valid during client 0's frame; commit+drop ends it
        applyStimulus(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hD0D0_0000);
        tick();
        checkOutput("peWord0", 128'(tcpTxBus.data), 128'hD0D0_0000);
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hD0D0_0001);
        applyStimulus(2, 1'b0, 1'b1, 1'b0, 1'b0, 32'hEEEE_EEEE);
        tick();
        checkOutput("peWord1", 128'(tcpTxBus.data), 128'hD0D0_0001);
        checkOutput("pePulse", 128'(protocolErr),   128'h1);
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hD0D0_0002);
        tick();
        checkOutput("pePulseLow", 128'(protocolErr),     128'h0);
        checkOutput("cdDrop",     128'(tcpTxBus.drop),   128'h1);
        checkOutput("cdCommit",   128'(tcpTxBus.commit), 128'h0);
        checkOutput("cdWord",     128'(tcpTxBus.data),   128'hD0D0_0002);
        checkOutput("cdBusy",     128'(busy),            128'h0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of client 1's frame
        clientRts[1] = 1'b1;
        tick();
        checkOutput("rsCts", 128'(clientCts), 128'h2);
        clientRts[1] = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hF0F0_0000);
        tick();
        checkOutput("rsStart", 128'(tcpTxBus.start), 128'h1);
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hF0F0_0001);
        rst = 1'b1;
        tick();
        checkOutput("rsBus",     128'(tcpTxBus), 128'h0);
        checkOutput("rsBusy",    128'(busy),     128'h0);
        checkOutput("rsGrantId", 128'(grantId),  128'h0);
        rst = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        clientRts[2] = 1'b1;
        clientRts[3] = 1'b1;
        tick();
        checkOutput("rsLowestCts", 128'(clientCts), 128'h4);
        checkOutput("rsLowestId",  128'(grantId),   128'h2);
        clientRts = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
